// File: rtl/vending_machine.sv
// Single-product vending controller: price 15, accepts 5- and 10-unit coins
// one per clock, emits registered one-cycle dispense and 5-unit change pulses.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  output logic       product,
  output logic       change
);

  // Credit states; 2'b11 is never entered in normal operation and recovers to S0.
  typedef enum logic [1:0] {
    S0       = 2'b00,
    S5       = 2'b01,
    S10      = 2'b10,
    S_UNUSED = 2'b11
  } state_t;

  // Coin codes; 2'b00 and 2'b11 both mean "no credit".
  localparam logic [1:0] COIN_5  = 2'b01;
  localparam logic [1:0] COIN_10 = 2'b10;

  state_t present;
  state_t next;
  logic   next_product;
  logic   next_change;

  // Next-state and next-output decode from current credit and the sampled coin.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    next         = present;
    next_product = 1'b0;
    next_change  = 1'b0;
    case (present)
      S0: begin
        if (coin == COIN_5)       next = S5;
        else if (coin == COIN_10) next = S10;
      end
      S5: begin
        if (coin == COIN_5) begin
          next = S10;
        end else if (coin == COIN_10) begin
          next         = S0;
          next_product = 1'b1;
        end
      end
      S10: begin
        if (coin == COIN_5) begin
          next         = S0;
          next_product = 1'b1;
        end else if (coin == COIN_10) begin
          next         = S0;
          next_product = 1'b1;
          next_change  = 1'b1;
        end
      end
      default: begin
        next = S0;
      end
    endcase
  end

  // State and output registers; outputs are registered so coin never reaches
  // product/change combinationally, and reset discards credit with no refund.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      present <= S0;
      product <= 1'b0;
      change  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same
      // pre-edge values, matching real flip-flop behaviour.
      present <= next;
      product <= next_product;
      change  <= next_change;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Self-checking bench for vending_machine: a credit-arithmetic model pushes
// expected state/outputs into a queue as each coin is driven; they are popped
// and compared one time unit after the sampling edge.
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic [1:0] coin;
  logic       product;
  logic       change;

  typedef struct packed {
    logic [1:0] present;
    logic       product;
    logic       change;
  } exp_t;

  exp_t exp_q[$];
  int   credit;
  int   n_checks;
  int   n_errors;

  vending_machine dut (
    .clk     (clk),
    .rst     (rst),
    .coin    (coin),
    .product (product),
    .change  (change)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: accumulate credit in units, vend at 15 or more.
  function automatic exp_t model_step(input logic [1:0] c);
    exp_t e;
    int   value;
    value = (c == 2'b01) ? 5 : (c == 2'b10) ? 10 : 0;
    credit += value;
    e.product = 1'b0;
    e.change  = 1'b0;
    if (credit >= 15) begin
      e.product = 1'b1;
      e.change  = (credit == 20);
      credit    = 0;
    end
    e.present = 2'(credit / 5);
    return e;
  endfunction

  // Drive one coin code for one edge and score the registered result.
  task automatic apply(input logic [1:0] c, input string name);
    exp_t e;
    @(negedge clk);
    coin = c;
    exp_q.push_back(model_step(c));
    @(posedge clk);
    #1;
    coin = 2'b00;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty, expected one entry", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " present"}, dut.present, e.present);
      check({name, " product"}, {1'b0, product}, {1'b0, e.product});
      check({name, " change"},  {1'b0, change},  {1'b0, e.change});
    end
  endtask

  task automatic check_idle_reset(input string name);
    check({name, " present"}, dut.present, 2'b00);
    check({name, " product"}, {1'b0, product}, 2'b00);
    check({name, " change"},  {1'b0, change},  2'b00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    credit   = 0;
    coin     = 2'b00;
    rst      = 1'b1;

    // Reset held across a clock edge.
    #10;
    check_idle_reset("reset");
    rst = 1'b0;

    // 5 then 10: vend without change.
    apply(2'b01, "a5");
    apply(2'b10, "a10");
    apply(2'b00, "a_idle");

    // 10 then 10: vend with change, both drop on the next edge.
    apply(2'b10, "b10");
    apply(2'b10, "b10b");
    apply(2'b00, "b_idle");

    // 5, 5, 5.
    apply(2'b01, "c5a");
    apply(2'b01, "c5b");
    apply(2'b01, "c5c");
    apply(2'b00, "c_idle");

    // Idle and invalid codes hold credit in S5, then 10 vends.
    apply(2'b01, "d5");
    for (int i = 0; i < 3; i++) begin
      apply(2'b11, $sformatf("d_inv%0d", i));
      apply(2'b00, $sformatf("d_none%0d", i));
    end
    apply(2'b10, "d10");
    apply(2'b00, "d_idle");

    // Consecutive purchases: 10, 10, 10, 01.
    apply(2'b10, "e10a");
    apply(2'b10, "e10b");
    apply(2'b10, "e10c");
    apply(2'b01, "e5");
    apply(2'b00, "e_idle");

    // Asynchronous reset mid-cycle with S10 credit clears immediately.
    apply(2'b10, "f10");
    #2;
    rst = 1'b1;
    credit = 0;
    #1;
    check_idle_reset("async_reset");
    @(negedge clk);
    check_idle_reset("reset_hold");
    rst = 1'b0;

    // Credit restarts from zero after reset.
    apply(2'b10, "g10");
    apply(2'b01, "g5");
    apply(2'b00, "g_idle");

    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
